// File: rtl/spi_frame_decoder_pkg.sv
// Shared definitions for the SPI side of the MIL/SPI converter:
// frame marker words, decoded word type and frame error codes.
package milStd1553;

    localparam logic [15:0] SPI_MARK_WSERV = 16'hFFA1;
    localparam logic [15:0] SPI_MARK_ESC   = 16'hFFA3;

    typedef enum logic {
        WORD_WDATA = 1'b0,
        WORD_WSERV = 1'b1
    } spi_word_type_e;

    typedef enum logic [1:0] {
        SPI_ERR_NONE    = 2'b00,
        SPI_ERR_CSUM    = 2'b01,
        SPI_ERR_MARKER  = 2'b10,
        SPI_ERR_TIMEOUT = 2'b11
    } spi_err_e;

    typedef enum logic [1:0] {
        MARK_NONE,
        MARK_WSERV,
        MARK_ESC
    } spi_mark_e;

endpackage

// File: rtl/spi_frame_decoder_timeout.sv
// Inter-word watchdog: counts idle cycles while enabled and flags when
// the gap reaches TIMEOUT; clear has priority and restarts the count.
module spi_frame_timeout #(
    parameter logic [15:0] TIMEOUT = 16'd4000
) (
    input  logic clk,
    input  logic nRst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] count;

    assign expired = (count == TIMEOUT);

    // NOTE: sequential state is updated with <= only, so every register
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/spi_frame_decoder.sv
// Frame-level receiver: matches the address word, strips WSERV/escape
// markers, streams decoded words and verifies checksum and packet number.
module spi_frame_decoder
    import milStd1553::*;
#(
    parameter logic [7:0]  BLOCK_ADDR = 8'hAB,
    parameter logic [15:0] TIMEOUT    = 16'd4000
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [15:0] rx_data,
    input  logic        rx_request,
    output logic        rx_done,
    output logic [15:0] out_data,
    output logic        out_type,
    output logic        out_request,
    output logic [7:0]  frame_cmd,
    output logic [7:0]  frame_size,
    output logic [15:0] frame_num,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD,
        S_DATA,
        S_CSUM,
        S_NUM,
        S_SKIP_HEAD,
        S_SKIP
    } state_e;

    localparam logic [15:0] ADDR_WORD = {BLOCK_ADDR, 8'h00};

    state_e         state, state_nxt, eff_state;
    logic [15:0]    sum, sum_nxt;
    logic [8:0]     remain, remain_nxt;
    spi_mark_e      mark, mark_nxt;
    logic [7:0]     cmd_nxt, size_nxt;
    logic [15:0]    num_nxt, out_data_nxt;
    spi_word_type_e out_type_q, out_type_nxt;
    logic           out_req_nxt, ok_nxt, err_nxt, is_marker;
    spi_err_e       err_code_q, err_code_nxt;
    logic           expired;

    spi_frame_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .nRst   (nRst),
        .clear  (rx_request || (state == S_IDLE)),
        .enable (state != S_IDLE),
        .expired(expired)
    );

    assign busy     = (state != S_IDLE);
    assign out_type = out_type_q;
    assign err_code = err_code_q;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        eff_state    = state;
        sum_nxt      = sum;
        remain_nxt   = remain;
        mark_nxt     = mark;
        cmd_nxt      = frame_cmd;
        size_nxt     = frame_size;
        num_nxt      = frame_num;
        out_data_nxt = out_data;
        out_type_nxt = out_type_q;
        out_req_nxt  = 1'b0;
        ok_nxt       = 1'b0;
        err_nxt      = 1'b0;
        err_code_nxt = SPI_ERR_NONE;
        is_marker    = 1'b0;

        // An expired gap aborts first; a word arriving in the same cycle
        // is then treated as if the decoder were already idle.
        if (expired && state != S_IDLE) begin
            eff_state = S_IDLE;
            state_nxt = S_IDLE;
            if (state inside {S_HEAD, S_DATA, S_CSUM, S_NUM}) begin
                err_nxt      = 1'b1;
                err_code_nxt = SPI_ERR_TIMEOUT;
            end
        end

        if (rx_request) begin
            case (eff_state)
                S_IDLE: begin
                    if (rx_data == ADDR_WORD) begin
                        sum_nxt   = rx_data;
                        state_nxt = S_HEAD;
                    end else if (rx_data[7:0] == 8'h00 && rx_data[15:8] != 8'h00) begin
                        state_nxt = S_SKIP_HEAD;
                    end
                end
                S_HEAD: begin
                    cmd_nxt    = rx_data[7:0];
                    size_nxt   = rx_data[15:8];
                    sum_nxt    = sum + rx_data;
                    remain_nxt = {1'b0, rx_data[15:8]};
                    mark_nxt   = MARK_NONE;
                    state_nxt  = (rx_data[15:8] == 8'h00) ? S_CSUM : S_DATA;
                end
                S_DATA: begin
                    sum_nxt    = sum + rx_data;
                    remain_nxt = remain - 9'd1;
                    is_marker  = (mark == MARK_NONE) &&
                                 (rx_data == SPI_MARK_WSERV || rx_data == SPI_MARK_ESC);
                    if (is_marker) begin
                        mark_nxt = (rx_data == SPI_MARK_WSERV) ? MARK_WSERV : MARK_ESC;
                    end else begin
                        out_req_nxt  = 1'b1;
                        out_data_nxt = rx_data;
                        out_type_nxt = (mark == MARK_WSERV) ? WORD_WSERV : WORD_WDATA;
                        mark_nxt     = MARK_NONE;
                    end
                    if (remain == 9'd1) begin
                        if (is_marker) begin
                            err_nxt      = 1'b1;
                            err_code_nxt = SPI_ERR_MARKER;
                            state_nxt    = S_IDLE;
                        end else begin
                            state_nxt = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (rx_data != sum) begin
                        err_nxt      = 1'b1;
                        err_code_nxt = SPI_ERR_CSUM;
                        state_nxt    = S_IDLE;
                    end else begin
                        state_nxt = S_NUM;
                    end
                end
                S_NUM: begin
                    num_nxt   = rx_data;
                    ok_nxt    = 1'b1;
                    state_nxt = S_IDLE;
                end
                S_SKIP_HEAD: begin
                    // Foreign frame: header size plus CSUM and NUM words.
                    remain_nxt = {1'b0, rx_data[15:8]} + 9'd2;
                    state_nxt  = S_SKIP;
                end
                S_SKIP: begin
                    remain_nxt = remain - 9'd1;
                    if (remain == 9'd1) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state       <= S_IDLE;
            sum         <= '0;
            remain      <= '0;
            mark        <= MARK_NONE;
            frame_cmd   <= '0;
            frame_size  <= '0;
            frame_num   <= '0;
            out_data    <= '0;
            out_type_q  <= WORD_WDATA;
            out_request <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            err_code_q  <= SPI_ERR_NONE;
            rx_done     <= 1'b0;
        end else begin
            state       <= state_nxt;
            sum         <= sum_nxt;
            remain      <= remain_nxt;
            mark        <= mark_nxt;
            frame_cmd   <= cmd_nxt;
            frame_size  <= size_nxt;
            frame_num   <= num_nxt;
            out_data    <= out_data_nxt;
            out_type_q  <= out_type_nxt;
            out_request <= out_req_nxt;
            frame_ok    <= ok_nxt;
            frame_err   <= err_nxt;
            err_code_q  <= err_code_nxt;
            rx_done     <= rx_request;
        end
    end

endmodule

// File: doc/spi_frame_decoder.md
# spi_frame_decoder

Packet-level receiver for the SPI side of the MIL/SPI converter. Consumes the 16-bit word stream produced by the SPI slave (one push per word), recognises frames addressed to this block, strips the WSERV/escape markers, streams decoded words to the command/memory logic, and verifies the trailing checksum and packet-number words. It is the consumer of the frame format that `DebugSpiTransmitter` and the reply generator emit.

## Interface
- `BLOCK_ADDR`, 8'hAB: frame address; matches address word `{BLOCK_ADDR, 8'h00}`.
- `TIMEOUT`, 16'd4000: max clk cycles between words inside a frame before abort.
- `clk  in  1`: system clock. One clock only.
- `nRst  in  1`: reset, asynchronous, active-low.
- `rx_data  in  16`: received word; valid when `rx_request`=1.
- `rx_request  in  1`: one-cycle word strobe. Back-to-back strobes are legal.
- `rx_done  out  1`: one-cycle acknowledge, the cycle after each `rx_request`.
- `out_data  out  16`: decoded payload word.
- `out_type  out  1`: 0 = WDATA, 1 = WSERV.
- `out_request  out  1`: one-cycle strobe per decoded word.
- `frame_cmd  out  8`, `frame_size  out  8`: from the header word, held until the next header.
- `frame_num  out  16`: packet number, valid with `frame_ok`.
- `frame_ok  out  1`: one-cycle pulse, frame accepted.
- `frame_err  out  1`: one-cycle pulse, frame aborted.
- `err_code  out  2`: valid with `frame_err`. 01 checksum, 10 dangling marker, 11 timeout.
- `busy  out  1`: high in any state other than IDLE.

## Operation
- Frame layout: ADDR `{addr,00}`, HEAD `{size,cmd}`, `size` raw data words, CSUM, NUM.
- CSUM is the 16-bit wrapping sum of ADDR, HEAD and all raw data words, markers included.
- Data-word decoding:
  - 16'hFFA1: the next word is emitted as WSERV.
  - 16'hFFA3: the next word is emitted as literal WDATA.
  - Any other word is WDATA.
  - Markers are never emitted, but they count toward `size` and the checksum.
- States:
  - IDLE
    - Word == `{BLOCK_ADDR,00}`: start the accumulator with it, go to HEAD.
    - Low byte 00 and high byte nonzero (a foreign address): go to SKIP_HEAD.
    - Any other word: dropped.
  - HEAD: latch `frame_size` and `frame_cmd`, add the word to the sum. Go to DATA, or to CSUM if size=0.
  - DATA: decrement the remaining count per word. Track the marker flag (none, WSERV, ESC).
    - If the last data word is a marker: `frame_err`, code 10, go to IDLE.
    - Otherwise, after the last word: go to CSUM.
  - CSUM
    - Mismatch: `frame_err`, code 01, go to IDLE.
    - Match: go to NUM.
  - NUM: latch `frame_num`, pulse `frame_ok`, go to IDLE.
  - SKIP_HEAD: read `size` from the word, set skip count = size+2, go to SKIP. No output.
  - SKIP: drop words until the count reaches 0, then go to IDLE. No status pulses.
- Timeout counter:
  - Cleared on every `rx_request` and held at 0 in IDLE.
  - On reaching `TIMEOUT` in HEAD/DATA/CSUM/NUM: `frame_err`, code 11, go to IDLE.
  - On reaching `TIMEOUT` in SKIP_HEAD/SKIP: go to IDLE silently.
- Words already emitted before an error stand. The downstream block discards the frame on `frame_err`.
- Reset mid-frame: everything returns to IDLE immediately; no pulse is generated.

## Timing
- Reset values: all outputs 0; `frame_cmd`, `frame_size` and `frame_num` are 0.
- Latency:
  - `rx_done` is exactly 1 cycle after `rx_request`.
  - `out_request` for a decoded word is asserted in the same cycle as that word's `rx_done`.
  - `frame_ok` or `frame_err` is asserted in the same cycle as the `rx_done` of the NUM or CSUM word.
- Throughput: one word per cycle sustained. A `rx_request` in the same cycle as a `rx_done` is accepted.
- A timeout abort takes priority over a simultaneous `rx_request`; that word is then evaluated in IDLE.
- All arithmetic is unsigned 16-bit with wrap. Counters are 9 bits, enough for size+2 ≤ 257.

## Structure
- `milStd1553` package gets:
  - constants `SPI_MARK_WSERV`=16'hFFA1 and `SPI_MARK_ESC`=16'hFFA3,
  - an enum for the word type (WDATA, WSERV),
  - an enum for the error codes.
- The state enum is local to the module.
- One sub-module, `spi_frame_timeout`: a counter with `clear`/`enable` inputs and an `expired` output.

## Test plan
- Good frame, BLOCK_ADDR=AB.
  - Stimulus: AB00, 06A2, FFA1, 0001, 0002, AB45, FFA3, FFA1, 5BCF, 0000.
  - Required: out = (WSERV 0001), (WDATA 0002), (WDATA AB45), (WDATA FFA1); `frame_ok` with cmd=A2, size=06, num=0000.
- Bad checksum: same frame with CSUM 5BCE -> four words still emitted, then `frame_err`, code 01, no `frame_ok`.
- Foreign frame.
  - Stimulus: AC00, 0AB2, ten 0000 words, B6B2, 0000, then the good AB frame.
  - Required: nothing emitted for AC; the AB frame decodes exactly as in test 1.
- Dangling marker: AB00, 01A2, FFA3, 0000 -> `frame_err`, code 10, no `out_request`.
- Timeout: AB00, 06A2, then silence for `TIMEOUT` cycles -> `frame_err`, code 11, `busy` drops; a following good frame is accepted.
- Zero-size frame plus padding.
  - Stimulus: 0000, 0000 padding, then AB00, 00A5, AB A5, 0007.
  - Required: padding ignored; `frame_ok` with num=0007, cmd=A5. `nRst` pulsed mid-frame yields no pulses.
